cofi_blend_ctrl: RTL and testbench

Frame-synchronous controller that sequences the CoFi smart blender. It tracks the pixel position from the incoming blank signals and holds host configuration in shadow registers. The configuration commits atomically at the start of vertical blank, so a mode change never takes effect mid-frame. It drives the blender's mode enables and a per-pixel force_blend for a rectangular window. It sits directly before the blender and delays the video stream by one ce_pixel so that the controls and the pixels arrive aligned.

---
 rtl/cofi_blend_ctrl_if.sv | 46 ++++
 rtl/cofi_blend_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cofi_blend_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cofi_blend_ctrl_if.sv
// Video + host-config bundle between the video source/host and the CoFi
// blend controller. The master side drives the raw video and config and
// observes the delayed, blend-annotated stream; the controller is the slave.
`timescale 1ns/1ps
interface cofi_blend_ctrl_if #(
  parameter int XW  = 11,
  parameter int FCW = 16
);
  // video in
  logic          ce_pixel;
  logic          hblank, vblank, hsync, vsync;
  logic [7:0]    red, green, blue;
  // host config (cfg_wr is a single-clk strobe, not ce-gated)
  logic          cfg_wr;
  logic          cfg_pattern, cfg_diff, cfg_hud, cfg_debug;
  logic          cfg_force_all, cfg_win_en;
  logic [XW-1:0] cfg_x0, cfg_x1, cfg_y0, cfg_y1;
  // video out, one ce behind the input
  logic          hblank_o, vblank_o, hsync_o, vsync_o;
  logic [7:0]    red_o, green_o, blue_o;
  // blender controls
  logic          force_blend;
  logic          pattern_blend, diff_blend, hud_filter, debug_view;
  // status / debug
  logic           cfg_pending;
  logic [FCW-1:0] frame_cnt;
  logic [XW-1:0]  pos_x, pos_y;

  modport master (
    output ce_pixel, hblank, vblank, hsync, vsync, red, green, blue,
    output cfg_wr, cfg_pattern, cfg_diff, cfg_hud, cfg_debug,
    output cfg_force_all, cfg_win_en, cfg_x0, cfg_x1, cfg_y0, cfg_y1,
    input  hblank_o, vblank_o, hsync_o, vsync_o, red_o, green_o, blue_o,
    input  force_blend, pattern_blend, diff_blend, hud_filter, debug_view,
    input  cfg_pending, frame_cnt, pos_x, pos_y
  );

  modport slave (
    input  ce_pixel, hblank, vblank, hsync, vsync, red, green, blue,
    input  cfg_wr, cfg_pattern, cfg_diff, cfg_hud, cfg_debug,
    input  cfg_force_all, cfg_win_en, cfg_x0, cfg_x1, cfg_y0, cfg_y1,
    output hblank_o, vblank_o, hsync_o, vsync_o, red_o, green_o, blue_o,
    output force_blend, pattern_blend, diff_blend, hud_filter, debug_view,
    output cfg_pending, frame_cnt, pos_x, pos_y
  );
endinterface

// File: rtl/cofi_blend_ctrl.sv
// CoFi smart-blender sequencer. Tracks raster position from the blank
// signals, double-buffers host config (pending -> active) with an atomic
// commit at each vblank rising edge, and emits a per-pixel force_blend for
// a rectangular window. Video is delayed by one ce so the controls and the
// pixel they belong to leave this block together.
`timescale 1ns/1ps
module cofi_blend_ctrl #(
  parameter int XW  = 11,
  parameter int FCW = 16
) (
  input logic              clk,
  input logic              reset,
  cofi_blend_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_VB = 2'd0,
    VBLANK  = 2'd1,
    ACTIVE  = 2'd2,
    HBL     = 2'd3
  } state_t;

  typedef struct packed {
    logic          pattern;
    logic          diff;
    logic          hud;
    logic          debug;
    logic          force_all;
    logic          win_en;
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [XW-1:0] y0;
    logic [XW-1:0] y1;
  } cfg_t;

  localparam logic [XW-1:0] XY_MAX = '1;

  state_t         state_q, state_d;
  cfg_t           cfg_in, pend_q, act_q;
  logic           pend_vld_q;
  logic [FCW-1:0] frame_cnt_q;

  // delayed video; the blank copies double as edge-detect history
  logic           vblank_dly_q, hblank_dly_q, hsync_q, vsync_q;
  logic [7:0]     red_q, green_q, blue_q;
  logic           force_q, force_d;

  logic [XW-1:0]  x_q, x_d, y_q, y_d;
  logic           vb_rise, vb_fall, hb_rise;
  logic           pix_act, in_win, commit;

  assign cfg_in = {bus.cfg_pattern, bus.cfg_diff, bus.cfg_hud, bus.cfg_debug,
                   bus.cfg_force_all, bus.cfg_win_en,
                   bus.cfg_x0, bus.cfg_x1, bus.cfg_y0, bus.cfg_y1};

  assign vb_rise = bus.vblank & ~vblank_dly_q;
  assign vb_fall = ~bus.vblank & vblank_dly_q;
  assign hb_rise = bus.hblank & ~hblank_dly_q;

  // Commit only on a real ce; a write on the same clk lands after the copy.
  assign commit  = bus.ce_pixel & vb_rise & pend_vld_q;

  // Next raster state from this ce's blanks (vb_rise wins over hblank)
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_VB: if (vb_rise)     state_d = VBLANK;
      VBLANK:  if (vb_fall)     state_d = bus.hblank ? HBL : ACTIVE;
      ACTIVE:  if (vb_rise)     state_d = VBLANK;
               else if (bus.hblank) state_d = HBL;
      HBL:     if (vb_rise)     state_d = VBLANK;
               else if (!bus.hblank) state_d = ACTIVE;
      default:                  state_d = WAIT_VB;
    endcase
  end

  // The state entered on this ce is the one the current pixel belongs to,
  // so the first pixel of a line (hblank just dropped) already counts.
  assign pix_act = (state_d == ACTIVE);

  // Window test uses the pre-increment position; x0>x1 or y0>y1 never hits.
  assign in_win = (x_q >= act_q.x0) && (x_q <= act_q.x1) &&
                  (y_q >= act_q.y0) && (y_q <= act_q.y1);

  assign force_d = pix_act & (act_q.force_all | (act_q.win_en & in_win));

  // Position counters: clear on frame/line start, saturate at all-ones
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (vb_rise) begin
      x_d = '0;
      y_d = '0;
    end else if (hb_rise) begin
      x_d = '0;
      if ((x_q != '0) && (y_q != XY_MAX)) y_d = y_q + XW'(1);
    end else if (pix_act && (x_q != XY_MAX)) begin
      x_d = x_q + XW'(1);
    end
  end

  // Raster state and position advance once per pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_VB;
      x_q     <= '0;
      y_q     <= '0;
    end else if (bus.ce_pixel) begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // One-ce video delay, with force_blend registered alongside the pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_dly_q <= 1'b0;
      hblank_dly_q <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      force_q      <= 1'b0;
    end else if (bus.ce_pixel) begin
      vblank_dly_q <= bus.vblank;
      hblank_dly_q <= bus.hblank;
      hsync_q      <= bus.hsync;
      vsync_q      <= bus.vsync;
      red_q        <= bus.red;
      green_q      <= bus.green;
      blue_q       <= bus.blue;
      force_q      <= force_d;
    end
  end

  // Host side: capture writes every clk, hand pending to active at commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else if (bus.cfg_wr) begin
      pend_q     <= cfg_in;
      pend_vld_q <= 1'b1;
    end else if (commit) begin
      pend_vld_q <= 1'b0;
    end
  end

  // Active set and commit counter change only at frame start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q       <= '0;
      frame_cnt_q <= '0;
    end else if (commit) begin
      act_q       <= pend_q;
      frame_cnt_q <= frame_cnt_q + FCW'(1);
    end
  end

  assign bus.hblank_o      = hblank_dly_q;
  assign bus.vblank_o      = vblank_dly_q;
  assign bus.hsync_o       = hsync_q;
  assign bus.vsync_o       = vsync_q;
  assign bus.red_o         = red_q;
  assign bus.green_o       = green_q;
  assign bus.blue_o        = blue_q;
  assign bus.force_blend   = force_q;

  // Until the first frame edge the blender runs with every mode off.
  assign bus.pattern_blend = act_q.pattern & (state_q != WAIT_VB);
  assign bus.diff_blend    = act_q.diff    & (state_q != WAIT_VB);
  assign bus.hud_filter    = act_q.hud     & (state_q != WAIT_VB);
  assign bus.debug_view    = act_q.debug   & (state_q != WAIT_VB);

  assign bus.cfg_pending   = pend_vld_q;
  assign bus.frame_cnt     = frame_cnt_q;
  assign bus.pos_x         = x_q;
  assign bus.pos_y         = y_q;

endmodule

// File: tb/tb_cofi_blend_ctrl.sv
// Directed bench for cofi_blend_ctrl: frames of 4 active lines x 8 pixels,
// a reference model of the pending/active config, and a scoreboard of
// expected per-pixel outputs checked one ce after each pixel is driven.
`timescale 1ns/1ps
module tb_cofi_blend_ctrl;
  localparam int XW   = 11;
  localparam int FCW  = 16;
  localparam int XMAX = (1 << XW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cofi_blend_ctrl_if #(.XW(XW), .FCW(FCW)) bus ();
  cofi_blend_ctrl #(.XW(XW), .FCW(FCW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic pat, dif, hud, dbg, fa, we;
    int   x0, x1, y0, y1;
  } mcfg_t;

  typedef struct {
    logic [27:0]    vid;
    logic           frc;
    logic [3:0]     modes;
    logic           pend;
    logic [FCW-1:0] fcnt;
  } exp_t;

  exp_t           sb[$];
  mcfg_t          new_cfg, m_pend, m_act;
  logic           m_pvld, m_seen, m_prev_vb;
  logic [FCW-1:0] m_fcnt;
  int             n_assert = 0;
  int             n_fail   = 0;
  int             force_seen = 0;
  bit             gap_en = 0;

  function automatic mcfg_t mk(input logic pat, dif, hud, dbg, fa, we,
                               input int x0, x1, y0, y1);
    mcfg_t c;
    c.pat = pat; c.dif = dif; c.hud = hud; c.dbg = dbg; c.fa = fa; c.we = we;
    c.x0 = x0; c.x1 = x1; c.y0 = y0; c.y1 = y1;
    return c;
  endfunction

  function automatic logic [27:0] obs_vid();
    return {bus.red_o, bus.green_o, bus.blue_o,
            bus.hblank_o, bus.vblank_o, bus.hsync_o, bus.vsync_o};
  endfunction

  function automatic logic [3:0] obs_modes();
    return {bus.pattern_blend, bus.diff_blend, bus.hud_filter, bus.debug_view};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = mk(0,0,0,0,0,0,0,0,0,0);
    m_act  = m_pend;
    m_pvld = 0; m_seen = 0; m_prev_vb = 0; m_fcnt = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vid"},   64'(obs_vid()), 64'd0);
    chk({tag, "_force"}, 64'(bus.force_blend), 64'd0);
    chk({tag, "_modes"}, 64'(obs_modes()), 64'd0);
    chk({tag, "_pend"},  64'(bus.cfg_pending), 64'd0);
    chk({tag, "_fcnt"},  64'(bus.frame_cnt), 64'd0);
    chk({tag, "_pos"},   64'({bus.pos_x, bus.pos_y}), 64'd0);
  endtask

  // Drive one pixel (one ce), predict its outputs, check them one ce later.
  task automatic pix(input logic hb, input logic vb, input int px, input int ly,
                     input logic wr);
    exp_t e;
    logic [7:0] r, g, b;
    logic hs, vs;
    int xc;
    @(negedge clk);
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    hs = 1'($urandom); vs = 1'($urandom);
    bus.ce_pixel = 1; bus.hblank = hb; bus.vblank = vb;
    bus.hsync = hs; bus.vsync = vs; bus.red = r; bus.green = g; bus.blue = b;
    bus.cfg_wr = wr;
    if (wr) begin
      bus.cfg_pattern = new_cfg.pat; bus.cfg_diff = new_cfg.dif;
      bus.cfg_hud = new_cfg.hud; bus.cfg_debug = new_cfg.dbg;
      bus.cfg_force_all = new_cfg.fa; bus.cfg_win_en = new_cfg.we;
      bus.cfg_x0 = XW'(new_cfg.x0); bus.cfg_x1 = XW'(new_cfg.x1);
      bus.cfg_y0 = XW'(new_cfg.y0); bus.cfg_y1 = XW'(new_cfg.y1);
    end
    // reference: commit on vblank rise uses the old pending set
    if (vb && !m_prev_vb) begin
      m_seen = 1;
      if (m_pvld) begin m_act = m_pend; m_fcnt = m_fcnt + 1'b1; m_pvld = 0; end
    end
    if (wr) begin m_pend = new_cfg; m_pvld = 1; end
    m_prev_vb = vb;
    xc = (px > XMAX) ? XMAX : px;
    e.vid   = {r, g, b, hb, vb, hs, vs};
    e.frc   = m_seen && !vb && !hb &&
              (m_act.fa || (m_act.we && m_act.x0 <= xc && xc <= m_act.x1 &&
                            m_act.y0 <= ly && ly <= m_act.y1));
    e.modes = m_seen ? {m_act.pat, m_act.dif, m_act.hud, m_act.dbg} : 4'b0;
    e.pend  = m_pvld;
    e.fcnt  = m_fcnt;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("video", 64'(obs_vid()), 64'(e.vid));
    chk("force_blend", 64'(bus.force_blend), 64'(e.frc));
    chk("modes", 64'(obs_modes()), 64'(e.modes));
    chk("cfg_pending", 64'(bus.cfg_pending), 64'(e.pend));
    chk("frame_cnt", 64'(bus.frame_cnt), 64'(e.fcnt));
    if (bus.force_blend === 1'b1) force_seen++;
    if (gap_en) begin
      @(negedge clk);
      bus.ce_pixel = 0; bus.cfg_wr = 0;
      bus.hblank = 1'($urandom); bus.vblank = 1'($urandom);
      bus.red = 8'($urandom); bus.green = 8'($urandom); bus.blue = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_video", 64'(obs_vid()), 64'(e.vid));
      chk("hold_force", 64'(bus.force_blend), 64'(e.frc));
      chk("hold_fcnt", 64'(bus.frame_cnt), 64'(e.fcnt));
    end
  endtask

  task automatic vline(input int wr_px);
    for (int p = 0; p < 8; p++) pix(0, 1, 0, 0, p == wr_px);
    for (int p = 0; p < 3; p++) pix(1, 1, 0, 0, (8 + p) == wr_px);
  endtask

  task automatic aline(input int ly, input int wr_px, input int len);
    for (int p = 0; p < len; p++) pix(0, 0, p, ly, p == wr_px);
    for (int p = 0; p < 3; p++) pix(1, 0, 0, ly, (len + p) == wr_px);
  endtask

  // wr_line: -1 none, -2 first vblank line, 0..3 active line
  task automatic frame(input int wr_line, input int wr_px);
    force_seen = 0;
    for (int l = 0; l < 2; l++) vline((wr_line == -2 && l == 0) ? wr_px : -1);
    for (int l = 0; l < 4; l++) aline(l, (wr_line == l) ? wr_px : -1, 8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ce_pixel = 0; bus.hblank = 0; bus.vblank = 0; bus.hsync = 0; bus.vsync = 0;
    bus.red = 0; bus.green = 0; bus.blue = 0; bus.cfg_wr = 0;
    bus.cfg_pattern = 0; bus.cfg_diff = 0; bus.cfg_hud = 0; bus.cfg_debug = 0;
    bus.cfg_force_all = 0; bus.cfg_win_en = 0;
    bus.cfg_x0 = 0; bus.cfg_x1 = 0; bus.cfg_y0 = 0; bus.cfg_y1 = 0;
    new_cfg = mk(0,0,0,0,0,0,0,0,0,0);
    model_reset();

    // reset state
    #2 reset = 1;
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 0;

    // pass-through before the first frame edge, then idle frames
    for (int p = 0; p < 5; p++) pix(0, 0, p, 0, 0);
    for (int f = 0; f < 3; f++) begin
      frame(-1, -1);
      chk("idle_force_cnt", 64'(force_seen), 64'd0);
    end
    chk("idle_fcnt", 64'(bus.frame_cnt), 64'd0);

    // pattern+diff written mid-line 2: only visible from the next frame
    new_cfg = mk(1,1,0,0,0,0,0,0,0,0);
    frame(2, 3);
    chk("pend_before_commit", 64'(bus.cfg_pending), 64'd1);
    new_cfg = mk(1,1,0,0,0,1,2,4,1,2);
    frame(1, 0);
    chk("fcnt_first_commit", 64'(bus.frame_cnt), 64'd1);

    // window 2..4 x 1..2 -> six forced pixels
    new_cfg = mk(1,1,0,0,0,1,5,3,1,2);
    frame(0, 4);
    chk("win_force_cnt", 64'(force_seen), 64'd6);

    // inverted window -> never forced
    new_cfg = mk(1,1,0,0,1,0,0,0,0,0);
    frame(3, 1);
    chk("empty_win_cnt", 64'(force_seen), 64'd0);

    // force_all -> all 32 active pixels
    new_cfg = mk(0,0,1,0,0,0,0,0,0,0);
    frame(1, 2);
    chk("force_all_cnt", 64'(force_seen), 64'd32);

    // write on the vb_rise ce: old pending commits, new one stays pending
    new_cfg = mk(0,0,0,1,0,1,0,7,3,3);
    frame(-2, 0);
    chk("same_clk_fcnt", 64'(bus.frame_cnt), 64'd5);
    chk("same_clk_pend", 64'(bus.cfg_pending), 64'd1);
    chk("same_clk_cnt", 64'(force_seen), 64'd0);

    // following frame commits the new set; ce gaps must hold every output
    gap_en = 1;
    frame(-1, -1);
    gap_en = 0;
    chk("second_commit_fcnt", 64'(bus.frame_cnt), 64'd6);
    chk("second_commit_pend", 64'(bus.cfg_pending), 64'd0);
    chk("row3_force_cnt", 64'(force_seen), 64'd8);

    // over-long line: x saturates, y still advances
    force_seen = 0;
    vline(-1); vline(-1);
    for (int p = 0; p < XMAX + 53; p++) pix(0, 0, p, 0, 0);
    chk("pos_x_sat", 64'(bus.pos_x), 64'(XMAX));
    pix(1, 0, 0, 0, 0);
    chk("pos_y_after_long", 64'(bus.pos_y), 64'd1);
    pix(1, 0, 0, 0, 0); pix(1, 0, 0, 0, 0);
    new_cfg = mk(0,0,0,0,0,1,2,4,1,2);
    aline(1, -1, 8); aline(2, 0, 8); aline(3, -1, 8);
    chk("long_frame_cnt", 64'(force_seen), 64'd8);

    // reset in the middle of a windowed line, with a write still pending
    force_seen = 0;
    vline(-1); vline(-1);
    aline(0, -1, 8);
    new_cfg = mk(0,0,0,0,1,0,0,0,0,0);
    for (int p = 0; p < 5; p++) pix(0, 0, p, 1, p == 3);
    chk("pre_reset_force", 64'(bus.force_blend), 64'd1);
    chk("pre_reset_pend", 64'(bus.cfg_pending), 64'd1);
    #2 reset = 1; bus.cfg_wr = 0;
    #1 chk_zero("midreset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;

    // no force until a frame edge plus a fresh commit
    for (int p = 0; p < 4; p++) pix(0, 0, p, 1, 0);
    frame(-1, -1);
    chk("post_reset_cnt", 64'(force_seen), 64'd0);
    chk("post_reset_fcnt", 64'(bus.frame_cnt), 64'd0);
    new_cfg = mk(0,0,0,0,0,1,2,4,1,2);
    frame(2, 5);
    chk("post_reset_wr_cnt", 64'(force_seen), 64'd0);
    frame(-1, -1);
    chk("post_reset_win_cnt", 64'(force_seen), 64'd6);
    chk("post_reset_fcnt1", 64'(bus.frame_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
